// File: rtl/bus_sram_responder.sv
// Purpose: bus target backed by a word-organised SRAM with byte/half/word lanes.
// Latency: grant is sampled by the core WAIT_CYCLES+1 edges after acceptance.
// Backpressure: o_BUS_GNT stays low (core stalls) until the access completes.
//
// Ports: i_CLK/i_RST clock and async active-high reset; i_BUS_REQ, i_BUS_CE,
// i_BUS_ADDR, i_BUS_WDATA, i_BUS_WE, i_BUS_HB request fields; o_BUS_GNT
// one-cycle completion pulse; o_BUS_RDATA read data (LSB-aligned, zero-filled);
// o_ERR misalignment flag coincident with the grant.
module bus_sram_responder #(
    parameter int CE_INDEX    = 0,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_BUS_REQ,
    input  logic [7:0]  i_BUS_CE,
    input  logic [31:0] i_BUS_ADDR,
    input  logic [31:0] i_BUS_WDATA,
    input  logic        i_BUS_WE,
    input  logic [1:0]  i_BUS_HB,
    output logic        o_BUS_GNT,
    output logic [31:0] o_BUS_RDATA,
    output logic        o_ERR
);
    localparam int         AW      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [AW+1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_we;
    logic [1:0]    lat_hb;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          sel;
    logic          enter_ack;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_we;
    logic [1:0]    acc_hb;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic          misalign;
    logic [3:0]    wmask;
    logic [31:0]   wdata_sh;
    logic [31:0]   rd_sh;
    logic [31:0]   rd_val;
    logic          do_write;

    // Address bits above the region and the other chip enables are ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{i_BUS_ADDR[31:AW+2], i_BUS_CE};

    assign sel = i_BUS_REQ & i_BUS_CE[CE_INDEX];

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (sel) begin
                    wait_cnt_nxt = WAIT_LD;
                    state_nxt    = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACK;
                end
            end
            ST_WAIT: begin
                if (!sel) begin
                    state_nxt = ST_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ACK never follows itself, so this marks the commit edge exactly once.
    assign enter_ack = (state_nxt == ST_ACK);

    // With zero wait states the commit edge is also the accept edge, so the
    // access is taken straight from the bus instead of the latched copy.
    assign acc_addr  = (state == ST_IDLE) ? i_BUS_ADDR[AW+1:0] : lat_addr;
    assign acc_wdata = (state == ST_IDLE) ? i_BUS_WDATA : lat_wdata;
    assign acc_we    = (state == ST_IDLE) ? i_BUS_WE : lat_we;
    assign acc_hb    = (state == ST_IDLE) ? i_BUS_HB : lat_hb;

    assign off      = acc_addr[1:0];
    assign idx      = acc_addr[AW+1:2];
    assign misalign = ((acc_hb == 2'b01) && off[0]) || (acc_hb[1] && (off != 2'b00));

    always_comb begin
        wmask = 4'b1111;
        case (acc_hb)
            2'b00:   wmask = 4'b0001 << off;
            2'b01:   wmask = 4'b0011 << off;
            default: wmask = 4'b1111;
        endcase
    end

    // Shifting the whole word is enough: the mask keeps only the live lanes.
    assign wdata_sh = acc_wdata << {off, 3'b000};
    assign rd_sh    = mem[idx] >> {off, 3'b000};

    always_comb begin
        rd_val = '0;
        case (acc_hb)
            2'b00:   rd_val = {24'd0, rd_sh[7:0]};
            2'b01:   rd_val = {16'd0, rd_sh[15:0]};
            default: rd_val = rd_sh;
        endcase
        if (misalign) begin
            rd_val = '0;
        end
    end

    assign do_write = enter_ack & acc_we & ~misalign;

    // SRAM contents survive reset.
    always_ff @(posedge i_CLK) begin
        if (do_write) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask[b]) begin
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            lat_hb      <= '0;
            o_BUS_GNT   <= 1'b0;
            o_BUS_RDATA <= '0;
            o_ERR       <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state == ST_IDLE && sel) begin
                lat_addr  <= i_BUS_ADDR[AW+1:0];
                lat_wdata <= i_BUS_WDATA;
                lat_we    <= i_BUS_WE;
                lat_hb    <= i_BUS_HB;
            end
            o_BUS_GNT   <= enter_ack;
            o_ERR       <= enter_ack & misalign;
            o_BUS_RDATA <= (enter_ack && !acc_we) ? rd_val : '0;
        end
    end
endmodule

// File: tb/tb_bus_sram_responder.sv
// Purpose: directed self-checking bench for bus_sram_responder.
// Latency: three instances (WAIT_CYCLES 1, 3, 0) share one bus on CE bits 0..2.
// Backpressure: requests are held until the grant is seen, then dropped.
module tb_bus_sram_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_req = 1'b0;
    logic [7:0]  bus_ce = '0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_we = 1'b0;
    logic [1:0]  bus_hb = '0;
    logic        gnt   [3];
    logic [31:0] rdata [3];
    logic        err   [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    bus_sram_responder #(.CE_INDEX(0), .DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u_dut_w1 (
        .i_CLK(clk), .i_RST(rst), .i_BUS_REQ(bus_req), .i_BUS_CE(bus_ce),
        .i_BUS_ADDR(bus_addr), .i_BUS_WDATA(bus_wdata), .i_BUS_WE(bus_we),
        .i_BUS_HB(bus_hb), .o_BUS_GNT(gnt[0]), .o_BUS_RDATA(rdata[0]), .o_ERR(err[0])
    );
    bus_sram_responder #(.CE_INDEX(1), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_dut_w3 (
        .i_CLK(clk), .i_RST(rst), .i_BUS_REQ(bus_req), .i_BUS_CE(bus_ce),
        .i_BUS_ADDR(bus_addr), .i_BUS_WDATA(bus_wdata), .i_BUS_WE(bus_we),
        .i_BUS_HB(bus_hb), .o_BUS_GNT(gnt[1]), .o_BUS_RDATA(rdata[1]), .o_ERR(err[1])
    );
    bus_sram_responder #(.CE_INDEX(2), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut_w0 (
        .i_CLK(clk), .i_RST(rst), .i_BUS_REQ(bus_req), .i_BUS_CE(bus_ce),
        .i_BUS_ADDR(bus_addr), .i_BUS_WDATA(bus_wdata), .i_BUS_WE(bus_we),
        .i_BUS_HB(bus_hb), .o_BUS_GNT(gnt[2]), .o_BUS_RDATA(rdata[2]), .o_ERR(err[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int ce, input logic we, input logic [1:0] hb,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        bus_req   = 1'b1;
        bus_ce    = 8'(1 << ce);
        bus_we    = we;
        bus_hb    = hb;
        bus_addr  = addr;
        bus_wdata = wd;
    endtask

    // Full access from IDLE; lat counts edges from accept to the edge that samples the grant.
    task automatic access(input int ce, input logic we, input logic [1:0] hb,
                          input logic [31:0] addr, input logic [31:0] wd, input logic scramble,
                          output logic [31:0] rd, output logic er, output int lat);
        int waited;
        drive(ce, we, hb, addr, wd);
        @(posedge clk); #1;
        if (scramble) begin
            bus_addr  = ~addr;
            bus_wdata = ~wd;
            bus_we    = ~we;
            bus_hb    = ~hb;
        end
        waited = 0;
        while (!gnt[ce] && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        chk($sformatf("gnt_seen_ce%0d_%08h", ce, addr), 32'(gnt[ce]), 32'd1);
        rd  = rdata[ce];
        er  = err[ce];
        lat = waited + 1;
        bus_req = 1'b0;
        bus_ce  = '0;
        @(posedge clk); #1;
        chk($sformatf("gnt_one_cycle_ce%0d_%08h", ce, addr), 32'(gnt[ce]), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          cnt;
        int          good;

        #2;
        chk("reset_gnt", 32'(gnt[0]), 32'd0);
        chk("reset_rdata", rdata[0], 32'd0);
        chk("reset_err", 32'(err[0]), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word write/read, WAIT_CYCLES=1
        access(0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 1'b0, rd, er, lat);
        chk("w1_write_latency", 32'(lat), 32'd2);
        access(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("w1_read_latency", 32'(lat), 32'd2);
        chk("w1_read_data", rd, 32'hDEADBEEF);
        chk("w1_read_err", 32'(er), 32'd0);
        chk("rdata_zero_after_gnt", rdata[0], 32'd0);

        // Byte and half lanes
        access(0, 1'b1, 2'b10, 32'h20, 32'h00000000, 1'b0, rd, er, lat);
        access(0, 1'b1, 2'b00, 32'h23, 32'hFFFFFFAB, 1'b0, rd, er, lat);
        access(0, 1'b1, 2'b01, 32'h20, 32'hFFFF1234, 1'b0, rd, er, lat);
        access(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("lanes_word", rd, 32'hAB001234);
        access(0, 1'b0, 2'b00, 32'h23, 32'h0, 1'b0, rd, er, lat);
        chk("lanes_byte3", rd, 32'h000000AB);
        access(0, 1'b0, 2'b00, 32'h21, 32'h0, 1'b0, rd, er, lat);
        chk("lanes_byte1", rd, 32'h00000012);
        access(0, 1'b0, 2'b01, 32'h22, 32'h0, 1'b0, rd, er, lat);
        chk("lanes_half_hi", rd, 32'h0000AB00);
        access(0, 1'b0, 2'b11, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("reserved_size_as_word", rd, 32'hAB001234);

        // Misaligned accesses
        access(0, 1'b1, 2'b10, 32'h22, 32'hFFFFFFFF, 1'b0, rd, er, lat);
        chk("misal_word_wr_err", 32'(er), 32'd1);
        access(0, 1'b0, 2'b01, 32'h21, 32'h0, 1'b0, rd, er, lat);
        chk("misal_half_rd_err", 32'(er), 32'd1);
        chk("misal_half_rd_data", rd, 32'd0);
        access(0, 1'b0, 2'b10, 32'h20, 32'h0, 1'b0, rd, er, lat);
        chk("misal_word_unchanged", rd, 32'hAB001234);
        chk("aligned_err_clear", 32'(er), 32'd0);

        // Address wrap
        access(0, 1'b1, 2'b10, 32'h0, 32'h5A5A5A5A, 1'b0, rd, er, lat);
        access(0, 1'b0, 2'b10, 32'h1000, 32'h0, 1'b0, rd, er, lat);
        chk("wrap_1000", rd, 32'h5A5A5A5A);
        access(0, 1'b0, 2'b10, 32'h80000000, 32'h0, 1'b0, rd, er, lat);
        chk("wrap_high_bit", rd, 32'h5A5A5A5A);

        // WAIT_CYCLES=3 instance: latency and latched fields
        access(1, 1'b1, 2'b10, 32'h40, 32'h11111111, 1'b0, rd, er, lat);
        chk("w3_latency", 32'(lat), 32'd4);
        access(1, 1'b1, 2'b10, 32'h44, 32'h33333333, 1'b0, rd, er, lat);
        access(1, 1'b1, 2'b10, 32'h48, 32'h44444444, 1'b1, rd, er, lat);
        chk("latched_no_err", 32'(er), 32'd0);
        access(1, 1'b0, 2'b10, 32'h48, 32'h0, 1'b0, rd, er, lat);
        chk("latched_write_data", rd, 32'h44444444);

        // Abort after one wait cycle
        drive(1, 1'b1, 2'b10, 32'h44, 32'h22222222);
        @(posedge clk);
        @(posedge clk); #1;
        bus_req = 1'b0;
        bus_ce  = '0;
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (gnt[1]) cnt++;
        end
        chk("abort_no_gnt", 32'(cnt), 32'd0);
        access(1, 1'b0, 2'b10, 32'h44, 32'h0, 1'b0, rd, er, lat);
        chk("abort_no_write", rd, 32'h33333333);

        // Deselect: only a CE bit nobody owns
        drive(3, 1'b0, 2'b10, 32'h10, 32'h0);
        cnt = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (gnt[0] || gnt[1] || gnt[2]) cnt++;
        end
        bus_req = 1'b0;
        bus_ce  = '0;
        chk("deselect_no_gnt", 32'(cnt), 32'd0);

        // Async reset mid-WAIT cancels the pending write
        drive(1, 1'b1, 2'b10, 32'h40, 32'h77777777);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rst_wait_gnt", 32'(gnt[1]), 32'd0);
        chk("rst_wait_rdata", rdata[1], 32'd0);
        chk("rst_wait_err", 32'(err[1]), 32'd0);
        bus_req = 1'b0;
        bus_ce  = '0;
        @(negedge clk);
        rst = 1'b0;
        access(1, 1'b0, 2'b10, 32'h40, 32'h0, 1'b0, rd, er, lat);
        chk("rst_wait_no_write", rd, 32'h11111111);

        // Async reset while the grant is up clears outputs without an edge
        drive(0, 1'b0, 2'b10, 32'h10, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_gnt", 32'(gnt[0]), 32'd1);
        chk("pre_rst_rdata", rdata[0], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        chk("rst_ack_gnt", 32'(gnt[0]), 32'd0);
        chk("rst_ack_rdata", rdata[0], 32'd0);
        bus_req = 1'b0;
        bus_ce  = '0;
        @(negedge clk);
        rst = 1'b0;
        access(0, 1'b0, 2'b10, 32'h10, 32'h0, 1'b0, rd, er, lat);
        chk("post_rst_data", rd, 32'hDEADBEEF);

        // WAIT_CYCLES=0: latency and throughput
        access(2, 1'b1, 2'b10, 32'h0, 32'hCAFEF00D, 1'b0, rd, er, lat);
        chk("w0_latency", 32'(lat), 32'd1);
        drive(2, 1'b0, 2'b10, 32'h0, 32'h0);
        cnt  = 0;
        good = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (gnt[2]) begin
                cnt++;
                if (rdata[2] == 32'hCAFEF00D) good++;
            end
        end
        bus_req = 1'b0;
        bus_ce  = '0;
        chk("w0_gnt_count", 32'(cnt), 32'd10);
        chk("w0_gnt_data", 32'(good), 32'd10);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
